// File: rtl/data_sync_tx_pkg.sv
// Shared definitions for the data_sync_tx CDC launcher: FSM state encoding
// and the default counter width.
package data_sync_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_RELEASE = 2'd3
  } tx_state_e;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/data_sync_tx_ack_sync.sv
// Multi-flop synchronizer that brings the destination-domain acknowledge level
// into the source clock domain.
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source-side launcher for a multi-bit CDC: holds a word on unsync_bus and
// frames it with bus_enable, completing on a 4-phase ack or fixed timing.
module data_sync_tx
  import data_sync_tx_pkg::*;
#(
  parameter int BUS_WIDTH    = 8,
  parameter int NUM_STAGES   = 2,
  parameter int USE_ACK      = 1,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int ACK_TIMEOUT  = 0,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 bus_ack,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 done,
  output logic                 timeout_err
);

  localparam bit ACK_EN = (USE_ACK != 0);
  localparam bit TO_EN  = ACK_EN && (ACK_TIMEOUT > 0);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  tx_state_e            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CNT_W-1:0]     wcnt, wcnt_nxt;
  logic                 aborted, aborted_nxt;
  logic [BUS_WIDTH-1:0] bus_nxt;
  logic                 en_nxt;
  logic                 done_nxt;
  logic                 err_nxt;
  logic                 ack_s;
  logic                 to_hit;

  ack_sync #(
    .STAGES(NUM_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus_ack),
    .q    (ack_s)
  );

  // Handshake: a word is taken on any rising clk edge where in_valid and
  // in_ready are both high; in_ready is high exactly while the FSM is IDLE.
  assign in_ready = (state == ST_IDLE);
  assign to_hit   = TO_EN && (wcnt >= TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      wcnt        <= '0;
      aborted     <= 1'b0;
      unsync_bus  <= '0;
      bus_enable  <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wcnt        <= wcnt_nxt;
      aborted     <= aborted_nxt;
      unsync_bus  <= bus_nxt;
      bus_enable  <= en_nxt;
      done        <= done_nxt;
      timeout_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = sat_inc(cnt);
    wcnt_nxt    = sat_inc(wcnt);
    aborted_nxt = aborted;
    bus_nxt     = unsync_bus;
    en_nxt      = bus_enable;
    done_nxt    = 1'b0;
    err_nxt     = timeout_err;

    unique case (state)
      ST_IDLE: begin
        en_nxt = 1'b0;
        if (in_valid) begin
          bus_nxt     = in_data;
          cnt_nxt     = '0;
          aborted_nxt = 1'b0;
          state_nxt   = ST_SETUP;
        end
      end

      // >= rather than == so a stale-ack stall resumes once the ack clears,
      // even though cnt has kept counting past the setup length.
      ST_SETUP: begin
        en_nxt = 1'b0;
        if ((cnt >= SETUP_LAST) && (!ACK_EN || !ack_s)) begin
          state_nxt = ST_ASSERT;
          en_nxt    = 1'b1;
          cnt_nxt   = '0;
          wcnt_nxt  = '0;
        end
      end

      ST_ASSERT: begin
        if ((cnt >= HOLD_LAST) && (!ACK_EN || ack_s)) begin
          state_nxt = ST_RELEASE;
          en_nxt    = 1'b0;
          cnt_nxt   = '0;
          wcnt_nxt  = '0;
        end else if (to_hit) begin
          state_nxt   = ST_RELEASE;
          en_nxt      = 1'b0;
          cnt_nxt     = '0;
          wcnt_nxt    = '0;
          err_nxt     = 1'b1;
          aborted_nxt = 1'b1;
        end
      end

      // An aborted transfer still honours the gap but no longer waits on ack.
      ST_RELEASE: begin
        en_nxt = 1'b0;
        if ((cnt >= GAP_LAST) && (!ACK_EN || aborted || !ack_s)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          done_nxt  = !aborted;
        end else if (to_hit && !aborted) begin
          err_nxt     = 1'b1;
          aborted_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: one timed-mode instance (a) and one 4-phase instance
// with a 16-cycle ack timeout (b), sharing one clock.
module tb_data_sync_tx;

  localparam int W     = 8;
  localparam int NS    = 2;
  localparam int SETUP = 1;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, in_valid_a, bus_ack_a, in_ready_a, bus_enable_a, done_a, timeout_err_a;
  logic [W-1:0] in_data_a, unsync_bus_a;
  logic         rst_b, in_valid_b, bus_ack_b, in_ready_b, bus_enable_b, done_b, timeout_err_b;
  logic [W-1:0] in_data_b, unsync_bus_b;

  data_sync_tx #(
    .BUS_WIDTH(W), .NUM_STAGES(NS), .USE_ACK(0), .SETUP_CYCLES(SETUP),
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .ACK_TIMEOUT(0), .CNT_W(8)
  ) dut_a (
    .clk(clk), .reset(rst_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .bus_ack(bus_ack_a), .unsync_bus(unsync_bus_a),
    .bus_enable(bus_enable_a), .done(done_a), .timeout_err(timeout_err_a)
  );

  data_sync_tx #(
    .BUS_WIDTH(W), .NUM_STAGES(NS), .USE_ACK(1), .SETUP_CYCLES(SETUP),
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO), .CNT_W(8)
  ) dut_b (
    .clk(clk), .reset(rst_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .bus_ack(bus_ack_b), .unsync_bus(unsync_bus_b),
    .bus_enable(bus_enable_b), .done(done_b), .timeout_err(timeout_err_b)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [W-1:0] hold_a, hold_b;
  logic prev_en_a = 1'b0;
  logic prev_en_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboard push: words the DUT accepts at this edge.
  always @(posedge clk) begin
    if (!rst_a) exp_a.delete();
    else if (in_valid_a && in_ready_a) exp_a.push_back(in_data_a);
    if (!rst_b) exp_b.delete();
    else if (in_valid_b && in_ready_b) exp_b.push_back(in_data_b);
  end

  // Scoreboard pop on done, plus bus stability while enable is high.
  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a++;
      if (exp_a.size() == 0) check("a_done_without_accept", 32'd1, 32'd0);
      else check("a_done_data", unsync_bus_a, exp_a.pop_front());
    end
    if (done_b) begin
      done_cnt_b++;
      if (exp_b.size() == 0) check("b_done_without_accept", 32'd1, 32'd0);
      else check("b_done_data", unsync_bus_b, exp_b.pop_front());
    end
    if (bus_enable_a && prev_en_a) check("a_bus_stable", unsync_bus_a, hold_a);
    if (bus_enable_b && prev_en_b) check("b_bus_stable", unsync_bus_b, hold_b);
    hold_a    = unsync_bus_a;
    hold_b    = unsync_bus_b;
    prev_en_a = bus_enable_a;
    prev_en_b = bus_enable_b;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] data;
    int en_first;
    int en_len;
    int ready_lat;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic [W-1:0] words[2];
    int acc_cyc[2];
    int idx, n, len, dc0, en_first, en_len, rdy;
    bit acc;

    rst_a = 0; rst_b = 0;
    in_valid_a = 0; in_valid_b = 0; bus_ack_a = 0; bus_ack_b = 0;
    in_data_a = '0; in_data_b = '0;
    repeat (3) step();
    check("a_rst_in_ready", in_ready_a, 1);
    check("a_rst_bus_enable", bus_enable_a, 0);
    check("a_rst_unsync_bus", unsync_bus_a, 0);
    check("a_rst_done", done_a, 0);
    check("a_rst_timeout_err", timeout_err_a, 0);
    check("b_rst_bus_enable", bus_enable_b, 0);
    check("b_rst_timeout_err", timeout_err_b, 0);
    rst_a = 1; rst_b = 1;
    step();

    // Timed mode: enable visible 1+SETUP cycles after accept for HOLD cycles,
    // ready again 1+SETUP+HOLD+GAP cycles after accept.
    vecs[0] = '{8'hA5, 1 + SETUP, HOLD, 1 + SETUP + HOLD + GAP};
    vecs[1] = '{8'h00, 1 + SETUP, HOLD, 1 + SETUP + HOLD + GAP};
    vecs[2] = '{8'hFF, 1 + SETUP, HOLD, 1 + SETUP + HOLD + GAP};
    vecs[3] = '{W'($urandom_range(1, 254)), 1 + SETUP, HOLD, 1 + SETUP + HOLD + GAP};
    for (int i = 0; i < 4; i++) begin
      dc0 = done_cnt_a;
      in_data_a = vecs[i].data;
      in_valid_a = 1;
      step();
      in_valid_a = 0;
      check("a_bus_after_accept", unsync_bus_a, vecs[i].data);
      check("a_busy_after_accept", in_ready_a, 0);
      en_first = -1; en_len = 0; rdy = -1;
      for (int k = 1; k <= 14; k++) begin
        if (k > 1) step();
        if (bus_enable_a) begin
          en_len++;
          if (en_first < 0) en_first = k;
        end
        if (in_ready_a && rdy < 0) rdy = k;
      end
      check("a_en_first", en_first, vecs[i].en_first);
      check("a_en_len", en_len, vecs[i].en_len);
      check("a_ready_lat", rdy, vecs[i].ready_lat);
      check("a_done_count", done_cnt_a - dc0, 1);
      check("a_bus_held_after", unsync_bus_a, vecs[i].data);
    end

    // Back-to-back with in_valid held high.
    words[0] = 8'h01; words[1] = 8'h02;
    acc_cyc[0] = -1; acc_cyc[1] = -1;
    idx = 0; dc0 = done_cnt_a;
    in_data_a = words[0]; in_valid_a = 1;
    for (int k = 0; k < 40; k++) begin
      acc = in_valid_a && in_ready_a;
      if (acc) acc_cyc[idx] = k;
      step();
      if (acc) begin
        idx++;
        if (idx < 2) in_data_a = words[idx];
        else in_valid_a = 0;
      end
    end
    check("a_b2b_accepts", idx, 2);
    check("a_b2b_spacing", acc_cyc[1] - acc_cyc[0], 1 + SETUP + HOLD + GAP);
    check("a_b2b_done_count", done_cnt_a - dc0, 2);
    check("a_b2b_last_word", unsync_bus_a, 8'h02);

    // Reset in the middle of ASSERT.
    dc0 = done_cnt_a;
    in_data_a = 8'h5A; in_valid_a = 1;
    step();
    in_valid_a = 0;
    for (int k = 0; k < 10 && !bus_enable_a; k++) step();
    check("a_rst_pre_enable", bus_enable_a, 1);
    step();
    rst_a = 0;
    step();
    check("a_midrst_bus_enable", bus_enable_a, 0);
    check("a_midrst_unsync_bus", unsync_bus_a, 0);
    check("a_midrst_in_ready", in_ready_a, 1);
    check("a_midrst_done", done_a, 0);
    rst_a = 1;
    repeat (10) step();
    check("a_midrst_no_done", done_cnt_a - dc0, 0);
    check("a_midrst_idle", in_ready_a, 1);
    check("a_midrst_enable_low", bus_enable_a, 0);

    // 4-phase: ack rises 10 cycles after enable, falls 5 cycles after enable drops.
    dc0 = done_cnt_b;
    in_data_b = 8'hC3; in_valid_b = 1;
    step();
    in_valid_b = 0;
    for (int k = 0; k < 10 && !bus_enable_b; k++) step();
    check("b_4p_enable_rise", bus_enable_b, 1);
    len = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus_enable_b) len++;
    end
    check("b_4p_enable_waits_ack", len, 10);
    bus_ack_b = 1;
    for (n = 1; n <= 20; n++) begin
      step();
      if (!bus_enable_b) break;
    end
    check("b_4p_fall_after_ack", n, NS + 1);
    repeat (5) step();
    check("b_4p_release_waits_ack", in_ready_b, 0);
    check("b_4p_bus_held", unsync_bus_b, 8'hC3);
    bus_ack_b = 0;
    for (n = 1; n <= 20; n++) begin
      step();
      if (in_ready_b) break;
    end
    check("b_4p_idle_after_ack_low", n, NS + 1);
    step();
    check("b_4p_done_count", done_cnt_b - dc0, 1);
    check("b_4p_no_timeout", timeout_err_b, 0);

    // Stale ack high at accept stalls SETUP.
    bus_ack_b = 1;
    repeat (4) step();
    dc0 = done_cnt_b;
    in_data_b = 8'h3C; in_valid_b = 1;
    step();
    in_valid_b = 0;
    len = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus_enable_b) len++;
    end
    check("b_stale_enable_held_low", len, 0);
    check("b_stale_busy", in_ready_b, 0);
    bus_ack_b = 0;
    for (n = 1; n <= 20; n++) begin
      step();
      if (bus_enable_b) break;
    end
    check("b_stale_rise_after_ack_low", n, NS + 1);
    bus_ack_b = 1;
    len = 1;
    for (int k = 0; k < 30 && bus_enable_b; k++) begin
      step();
      if (bus_enable_b) len++;
    end
    check("b_stale_hold_len", len, HOLD);
    bus_ack_b = 0;
    for (int k = 0; k < 20 && !in_ready_b; k++) step();
    step();
    check("b_stale_done_count", done_cnt_b - dc0, 1);
    check("b_stale_queue_empty", exp_b.size(), 0);

    // Ack never arrives: timeout after TMO cycles in ASSERT.
    dc0 = done_cnt_b;
    in_data_b = 8'h7E; in_valid_b = 1;
    step();
    in_valid_b = 0;
    for (int k = 0; k < 10 && !bus_enable_b; k++) step();
    check("b_to_enable_rise", bus_enable_b, 1);
    len = 1;
    for (int k = 0; k < 40 && bus_enable_b; k++) begin
      step();
      if (bus_enable_b) len++;
    end
    check("b_to_enable_len", len, TMO);
    check("b_to_err_set", timeout_err_b, 1);
    for (n = 1; n <= 20; n++) begin
      step();
      if (in_ready_b) break;
    end
    check("b_to_ready_after_gap", n, GAP);
    step();
    check("b_to_no_done", done_cnt_b - dc0, 0);
    check("b_to_word_unfinished", exp_b.size(), 1);
    exp_b.delete();
    repeat (5) step();
    check("b_to_err_sticky", timeout_err_b, 1);
    rst_b = 0;
    step();
    check("b_to_err_cleared", timeout_err_b, 0);
    rst_b = 1;
    step();

    check("a_queue_empty", exp_a.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
